// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM state type
// and the default operand width.
package div_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract
// the divisor magnitude, keep or restore. Ports: rem/bit_in/divisor in,
// rem_next/q_bit out.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted = {rem, bit_in};
  assign diff    = {1'b0, shifted[WIDTH-1:0]} - {1'b0, divisor};

  // A set top bit means the shifted value is >= 2^WIDTH, which always
  // exceeds the divisor; the low-bit difference is then exact mod 2^WIDTH.
  assign q_bit    = shifted[WIDTH] | ~diff[WIDTH];
  assign rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, signed/unsigned, one bit per cycle.
// Ports: clk, reset, start, signed_mode, Dividend, Divisor in;
// busy, done, Quotient, Remainder, div_by_zero out.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH     = DIV_WIDTH,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t state, state_n;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic             neg_q;
  logic             neg_r;
  logic             dz_q;

  logic             sgn;
  logic             accept;
  logic             last;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] rem_next;
  logic             q_bit;

  assign sgn    = SIGNED_EN && signed_mode;
  assign accept = (state == IDLE) && start;
  assign last   = (cnt == CW'(WIDTH - 1));
  assign a_mag  = (sgn && Dividend[WIDTH-1]) ? -Dividend : Dividend;
  assign b_mag  = (sgn && Divisor[WIDTH-1]) ? -Divisor : Divisor;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .bit_in   (quo_q[WIDTH-1]),
    .divisor  (dvs_q),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (start) state_n = (Divisor == '0) ? DONE : CALC;
      CALC: if (last) state_n = FIX;
      FIX:  state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // quo_q starts as the dividend magnitude and is shifted out MSB-first
  // while quotient bits shift in at the bottom.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz_q        <= 1'b0;
      done        <= 1'b0;
      Quotient    <= '0;
      Remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= (state == DONE);
      case (state)
        IDLE: begin
          if (accept) begin
            cnt <= '0;
            if (Divisor == '0) begin
              quo_q <= '1;
              rem_q <= Dividend;
              dz_q  <= 1'b1;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
            end else begin
              quo_q <= a_mag;
              rem_q <= '0;
              dvs_q <= b_mag;
              dz_q  <= 1'b0;
              neg_q <= sgn && (Dividend[WIDTH-1] ^ Divisor[WIDTH-1]);
              neg_r <= sgn && Dividend[WIDTH-1];
            end
          end
        end
        CALC: begin
          rem_q <= rem_next;
          quo_q <= {quo_q[WIDTH-2:0], q_bit};
          cnt   <= cnt + CW'(1);
        end
        FIX: begin
          if (neg_q) quo_q <= -quo_q;
          if (neg_r) rem_q <= -rem_q;
        end
        DONE: begin
          Quotient    <= quo_q;
          Remainder   <= rem_q;
          div_by_zero <= dz_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, meaning operand and result width in bits (legal range 4..64).
REQ-002 The module SHALL have parameter SIGNED_EN, default 1, meaning signed mode is supported; when 0, signed_mode is ignored and treated as 0.
REQ-003 Port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port start, input, 1 bit: request a division; accepted only when busy=0.
REQ-006 Port signed_mode, input, 1 bit: 1 means two's-complement operands; sampled with start.
REQ-007 Ports Dividend and Divisor, input, WIDTH bits each: operands, sampled on the accepted start.
REQ-008 Port busy, output, 1 bit: high from the cycle after an accepted start until done.
REQ-009 Port done, output, 1 bit: one-cycle pulse marking valid results.
REQ-010 Ports Quotient and Remainder, output, WIDTH bits each: registered results.
REQ-011 Port div_by_zero, output, 1 bit: set with done when Divisor was 0.

Function
REQ-012 FSM states SHALL be IDLE, CALC, FIX, DONE; IDLE->CALC on accepted start with nonzero Divisor; IDLE->DONE on accepted start with zero Divisor; CALC->FIX after WIDTH iterations; FIX->DONE; DONE->IDLE unconditionally.
REQ-013 A start SHALL be accepted only in IDLE; start in any other state SHALL be ignored with no effect.
REQ-014 CALC SHALL perform one restoring step per cycle: shift {partial remainder, dividend bit} left by one, trial-subtract the divisor magnitude in WIDTH+1 bits, keep the result and set the quotient bit to 1 if non-negative, else restore and set 0.
REQ-015 In signed mode, operands SHALL be converted to magnitudes at accept; FIX SHALL negate Quotient if operand signs differ and negate Remainder if Dividend was negative (truncation toward zero, remainder takes Dividend's sign).
REQ-016 In unsigned mode, FIX SHALL pass magnitudes through unchanged.
REQ-017 Latency SHALL be exactly WIDTH+2 cycles from the start-sampling edge to done=1 for nonzero Divisor, and exactly 1 cycle (done in the cycle after acceptance) for zero Divisor.
REQ-018 Divide by zero SHALL yield Quotient=all ones, Remainder=Dividend, div_by_zero=1, in both modes.
REQ-019 Signed overflow (most-negative / -1) SHALL yield Quotient=most-negative, Remainder=0, div_by_zero=0.
REQ-020 Quotient, Remainder, div_by_zero SHALL update only in the done cycle and hold until the next done or reset.
REQ-021 A start asserted in the DONE cycle SHALL be ignored; a start in the following IDLE cycle SHALL be accepted (throughput one result per WIDTH+3 cycles).

Reset
REQ-022 While reset=1 at a clock edge, FSM SHALL go to IDLE and busy, done, div_by_zero, Quotient, Remainder SHALL become 0.
REQ-023 Reset mid-operation SHALL abort the division with no done pulse; reset SHALL take priority over a simultaneous start.

Structure
REQ-024 A shared package div_pkg SHALL hold the FSM state type and the default width constant.
REQ-025 One restoring step SHALL be a sub-module div_step (WIDTH+1-bit trial subtract and select), instantiated once and reused every CALC cycle.
REQ-026 The iteration counter SHALL be $clog2(WIDTH+1) bits wide.

Verification (WIDTH=32)
REQ-027 Unsigned 100 / 7, start one cycle -> done at cycle 34, Quotient=14, Remainder=2, div_by_zero=0.
REQ-028 Signed -7 / 2 -> Quotient=-3 (0xFFFFFFFD), Remainder=-1 (0xFFFFFFFF); signed 0x80000000 / 0xFFFFFFFF -> Quotient=0x80000000, Remainder=0.
REQ-029 Divisor=0, Dividend=0x1234 -> done in the cycle after acceptance, Quotient=0xFFFFFFFF, Remainder=0x1234, div_by_zero=1.
REQ-030 start re-asserted while busy with different operands -> ignored, first result unchanged; start held continuously -> new division accepted in IDLE, second done at WIDTH+3 cycles after the first.
REQ-031 reset asserted at cycle 10 of a division -> no done pulse, all outputs 0, next start behaves per REQ-027.
REQ-032 Random 10k signed and unsigned operand pairs -> results match reference-model / and % with truncation toward zero.
